program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 32, giving the instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the word and address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a load request sampled in IDLE, DONE and ERROR.
REQ-006 SHALL have port byte_in, input, 8, the stream byte.
REQ-007 SHALL have port byte_valid, input, 1, meaning byte_in holds a valid byte.
REQ-008 SHALL have port byte_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-009 SHALL have port WriteEnable, output, 1, the instruction-memory write strobe.
REQ-010 SHALL have port WriteAddress, output, DATA_WIDTH, the byte address, always word-aligned.
REQ-011 SHALL have port WriteData, output, DATA_WIDTH, the instruction word to write.
REQ-012 SHALL have port cpu_hold, output, 1, which holds the processor in reset or stall while high.
REQ-013 SHALL have port done, output, 1, meaning the load completed.
REQ-014 SHALL have port error, output, 1, meaning the load was rejected because of its length.

Function
REQ-015 SHALL transfer a byte only on a cycle where both byte_valid and byte_ready are high.
REQ-016 SHALL implement the states IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE and ERROR.
REQ-017 SHALL move from IDLE, DONE or ERROR to HDR_HI on start=1, clearing done, error, the byte counter and the word index.
REQ-018 SHALL ignore start in HDR_HI, HDR_LO, DATA and WRITE.
REQ-019 SHALL, in HDR_HI, accept byte N[15:8] of the word count N and then go to HDR_LO.
REQ-020 SHALL, in HDR_LO, accept byte N[7:0], then:
- go to ERROR if N > MEMORY_DEPTH;
- go to DONE if N = 0;
- otherwise go to DATA.
REQ-021 SHALL, in DATA, accept bytes most-significant first; after the 4th byte of a word it SHALL go to WRITE.
REQ-022 SHALL, in WRITE, which lasts exactly one cycle, drive WriteEnable=1, WriteData=the assembled word and WriteAddress={word_index, 2'b00}, with byte_ready=0.
REQ-023 SHALL leave WRITE for DONE if the incremented word index equals N, and for DATA otherwise.
REQ-024 SHALL keep byte_ready=1 only in HDR_HI, HDR_LO and DATA, and 0 in all other states.
REQ-025 SHALL hold WriteEnable=0 in every state except WRITE; WriteAddress and WriteData are don't-care when WriteEnable=0.
REQ-026 SHALL put the first WriteEnable pulse exactly one cycle after the accept of the 4th data byte, so back-to-back streams produce one write per 5 cycles.
REQ-027 SHALL tolerate byte_valid gaps of any length in any byte-accepting state without changing the written result.
REQ-028 SHALL, in DONE, hold done=1 and cpu_hold=0 until start or reset.
REQ-029 SHALL, in ERROR, hold error=1 and cpu_hold=1, perform no writes, and stay there until start or reset.
REQ-030 SHALL keep cpu_hold=1 in every state except DONE.
REQ-031 SHALL treat N = MEMORY_DEPTH as legal, with the last write at byte address 4*(MEMORY_DEPTH-1).
REQ-032 SHALL size the word-index counter to hold MEMORY_DEPTH without wrap-around; no write address SHALL reach 4*MEMORY_DEPTH.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, enter IDLE with byte_ready=0, WriteEnable=0, done=0, error=0, cpu_hold=1 and all counters 0.
REQ-034 SHALL give reset priority over start and byte transfers in the same cycle.
REQ-035 SHALL, on reset mid-load, abandon the load immediately with no further WriteEnable pulse; words already written remain in memory.

Verification
REQ-036 Reset scenario: assert reset for 2 cycles -> byte_ready=0, WriteEnable=0, done=0, error=0, cpu_hold=1.
REQ-037 Two-word load: start, then bytes 00 02 20 08 00 05 8C 09 00 00 -> two writes, then done=1 and cpu_hold=0:
- write 1 at address 0x00000000, data 0x20080005;
- write 2 at address 0x00000004, data 0x8C090000.
REQ-038 Oversize header: start, then bytes 00 21 -> error=1, byte_ready=0, no WriteEnable pulse, cpu_hold=1.
REQ-039 Empty load: start, then bytes 00 00 -> done=1 on the cycle after the accept, no writes; byte_valid gaps inserted into the REQ-037 stream -> identical writes.
REQ-040 Full-capacity and abort cases:
- N=32 -> 32 writes, the last at 0x0000007C, then done=1;
- reset after the 2nd data byte -> IDLE, no write; a following start restarts cleanly.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
// The slave modport is the loader's view; master is the host/memory side.
interface program_loader_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  WriteEnable;
  logic [DATA_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, WriteEnable, WriteAddress, WriteData
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, WriteEnable, WriteAddress, WriteData
  );
endinterface

// File: rtl/program_loader.sv
// Receives a 16-bit word count followed by big-endian instruction words over a
// byte stream and writes them to instruction memory while holding the CPU.
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);
  // Wide enough to hold MEMORY_DEPTH itself, so a full load never wraps.
  localparam int IW = $clog2(MEMORY_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  ready_q, we_q, done_q, error_q, hold_q;
  logic                  accept;
  logic [15:0]           hdr_n;
  logic [IW-1:0]         idx_inc;

  assign accept  = bus.byte_valid && ready_q;
  assign hdr_n   = {count_q[15:8], bus.byte_in};
  assign idx_inc = idx_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = HDR_HI;
          byte_cnt_d = 2'd0;
          idx_d      = '0;
        end
      end
      HDR_HI: begin
        if (accept) begin
          count_d[15:8] = bus.byte_in;
          state_d       = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = hdr_n;
          if (int'(hdr_n) > MEMORY_DEPTH) begin
            state_d = ERROR;
          end else if (hdr_n == 16'd0) begin
            state_d = DONE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d     = {word_q[DATA_WIDTH-9:0], bus.byte_in};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        idx_d   = idx_inc;
        state_d = (16'(idx_inc) == count_q) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      byte_cnt_q <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      ready_q    <= (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == DATA);
      we_q       <= (state_d == WRITE);
      done_q     <= (state_d == DONE);
      error_q    <= (state_d == ERROR);
      hold_q     <= (state_d != DONE);
    end
  end

  assign bus.byte_ready   = ready_q;
  assign bus.WriteEnable  = we_q;
  assign bus.WriteData    = word_q;
  assign bus.WriteAddress = DATA_WIDTH'({idx_q, 2'b00});
  assign cpu_hold         = hold_q;
  assign done             = done_q;
  assign error            = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a byte-count level model predicts every
// output each cycle, and logged writes are compared against the generated program.
module tb_program_loader;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic done;
  logic error;
  logic cpuHold;

  program_loader_if #(.DATA_WIDTH(32)) bus ();

  program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpuHold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];

  bit         modelOn = 1'b0;
  bit         mLoading, mWriteNow, mFinished, mRejected;
  int         mHdrCnt, mDataCnt, mWords;
  logic [7:0] mHi;
  logic [7:0] mData[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelWord(input int lastByte);
    return {mData[lastByte-3], mData[lastByte-2], mData[lastByte-1], mData[lastByte]};
  endfunction

  // The model tracks how many header and data bytes have been accepted; a
  // write is due the cycle after every fourth data byte.
  initial begin
    forever begin
      @(negedge clk);
      if (modelOn) begin
        checkOutput("byte_ready", 32'(bus.byte_ready), 32'(mLoading && !mWriteNow));
        checkOutput("WriteEnable", 32'(bus.WriteEnable), 32'(mWriteNow));
        checkOutput("done", 32'(done), 32'(mFinished));
        checkOutput("error", 32'(error), 32'(mRejected));
        checkOutput("cpu_hold", 32'(cpuHold), 32'(!mFinished));
        if (mWriteNow) begin
          checkOutput("WriteAddress", bus.WriteAddress, 32'(4 * (mDataCnt / 4 - 1)));
          checkOutput("WriteData", bus.WriteData, modelWord(mDataCnt - 1));
        end
      end
      if (bus.WriteEnable === 1'b1) begin
        wrAddrQ.push_back(bus.WriteAddress);
        wrDataQ.push_back(bus.WriteData);
      end
      if (reset) begin
        modelOn   = 1'b1;
        mLoading  = 1'b0;
        mWriteNow = 1'b0;
        mFinished = 1'b0;
        mRejected = 1'b0;
        mHdrCnt   = 0;
        mDataCnt  = 0;
        mData.delete();
      end else if (mWriteNow) begin
        mWriteNow = 1'b0;
        if (mDataCnt == 4 * mWords) begin
          mLoading  = 1'b0;
          mFinished = 1'b1;
        end
      end else if (mLoading && bus.byte_valid) begin
        if (mHdrCnt == 0) begin
          mHi     = bus.byte_in;
          mHdrCnt = 1;
        end else if (mHdrCnt == 1) begin
          mHdrCnt = 2;
          mWords  = int'({mHi, bus.byte_in});
          if (mWords > DEPTH) begin
            mLoading  = 1'b0;
            mRejected = 1'b1;
          end else if (mWords == 0) begin
            mLoading  = 1'b0;
            mFinished = 1'b1;
          end
        end else begin
          mData.push_back(bus.byte_in);
          mDataCnt++;
          if (mDataCnt % 4 == 0) mWriteNow = 1'b1;
        end
      end else if (!mLoading && start) begin
        mLoading  = 1'b1;
        mFinished = 1'b0;
        mRejected = 1'b0;
        mHdrCnt   = 0;
        mDataCnt  = 0;
        mData.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Random idle gaps (optionally with stray start pulses) precede each byte.
  task automatic sendByte(input logic [7:0] b, input int maxGap, input bit randStart);
    int gap;
    bit got;
    gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
      start          = randStart ? 1'($urandom) : 1'b0;
      tick();
    end
    start          = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    got            = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = bus.byte_ready;
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
    checkOutput("byte_accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic applyStimulus(input int n, input logic [31:0] words[$], input int maxGap,
                               input bit randStart);
    int base;
    logic [15:0] n16;
    base = wrAddrQ.size();
    n16  = 16'(n);
    startLoad();
    sendByte(n16[15:8], maxGap, randStart);
    sendByte(n16[7:0], maxGap, randStart);
    if (n <= DEPTH) begin
      for (int w = 0; w < n; w++) begin
        for (int k = 3; k >= 0; k--) begin
          sendByte(words[w][8*k +: 8], maxGap, randStart);
        end
      end
    end
    for (int i = 0; i < 50 && !(done || error); i++) tick();
    if (n > DEPTH) begin
      checkOutput("load_error", 32'(error), 32'd1);
      checkOutput("err_byte_ready", 32'(bus.byte_ready), 32'd0);
      checkOutput("err_cpu_hold", 32'(cpuHold), 32'd1);
      checkOutput("err_write_count", 32'(wrAddrQ.size() - base), 32'd0);
    end else begin
      checkOutput("load_done", 32'(done), 32'd1);
      checkOutput("done_cpu_hold", 32'(cpuHold), 32'd0);
      checkOutput("write_count", 32'(wrAddrQ.size() - base), 32'(n));
      for (int w = 0; w < n && base + w < wrAddrQ.size(); w++) begin
        checkOutput("mem_addr", wrAddrQ[base + w], 32'(4 * w));
        checkOutput("mem_data", wrDataQ[base + w], words[w]);
      end
    end
  endtask

  task automatic checkTwoWordLiterals(input int base);
    checkOutput("lit_addr0", wrAddrQ[base], 32'h0000_0000);
    checkOutput("lit_data0", wrDataQ[base], 32'h2008_0005);
    checkOutput("lit_addr1", wrAddrQ[base + 1], 32'h0000_0004);
    checkOutput("lit_data1", wrDataQ[base + 1], 32'h8C09_0000);
  endtask

  initial begin
    logic [31:0] words[$];
    logic [31:0] none[$];
    int base;
    int n;

    reset          = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("rst_we", 32'(bus.WriteEnable), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_cpu_hold", 32'(cpuHold), 32'd1);

    words = '{32'h2008_0005, 32'h8C09_0000};
    base  = wrAddrQ.size();
    applyStimulus(2, words, 0, 1'b0);
    checkTwoWordLiterals(base);

    applyStimulus(33, none, 0, 1'b0);

    base = wrAddrQ.size();
    startLoad();
    sendByte(8'h00, 0, 1'b0);
    sendByte(8'h00, 0, 1'b0);
    checkOutput("empty_done_next_cycle", 32'(done), 32'd1);
    tick();
    checkOutput("empty_write_count", 32'(wrAddrQ.size() - base), 32'd0);

    base = wrAddrQ.size();
    applyStimulus(2, words, 4, 1'b1);
    checkTwoWordLiterals(base);

    words.delete();
    for (int w = 0; w < DEPTH; w++) words.push_back($urandom);
    base = wrAddrQ.size();
    applyStimulus(DEPTH, words, 2, 1'b1);
    checkOutput("full_last_addr", wrAddrQ[wrAddrQ.size() - 1], 32'h0000_007C);

    // Abort after two data bytes, with start and a valid byte colliding with reset.
    base = wrAddrQ.size();
    startLoad();
    sendByte(8'h00, 0, 1'b0);
    sendByte(8'h01, 0, 1'b0);
    sendByte(8'hAA, 0, 1'b0);
    sendByte(8'hBB, 0, 1'b0);
    reset          = 1'b1;
    start          = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hCC;
    tick();
    reset          = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    checkOutput("abort_byte_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("abort_cpu_hold", 32'(cpuHold), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    repeat (4) tick();
    checkOutput("abort_write_count", 32'(wrAddrQ.size() - base), 32'd0);
    words = '{32'h2008_0005, 32'h8C09_0000};
    applyStimulus(2, words, 1, 1'b0);
    checkTwoWordLiterals(base);

    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(9, 0))
        0:       n = 0;
        1:       n = DEPTH;
        2:       n = DEPTH + 1;
        3:       n = 300;
        default: n = int'($urandom_range(8, 1));
      endcase
      words.delete();
      for (int w = 0; w < n && w < DEPTH; w++) words.push_back($urandom);
      applyStimulus(n, words, 3, 1'b1);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
